memchr_reader: RTL

Read-side companion to the memset engine. It scans n consecutive bytes starting at base address m through the memory_controller interface and reports the address of the first byte equal to c[7:0]. Reads are pipelined: one address is issued per cycle. Returned data is matched against a tag pipeline that absorbs the registered-RAM read latency. It sits beside memset as a peer master of memory_controller, using the same start/finish/return_val handshake.

---
 rtl/memchr_reader_pkg.sv | 20 ++
 rtl/memchr_reader_if.sv | 26 ++
 rtl/memchr_tag_pipe.sv | 30 +++
 rtl/memchr_reader.sv | 130 +++++++++++++
 4 files changed

// File: rtl/memchr_reader_pkg.sv
// rtl/memchr_reader_pkg.sv - shared types and sizes for the memchr read engine
package memchr_reader_pkg;

  localparam int MEMORY_CONTROLLER_ADDR_SIZE = 32;
  localparam int MEMORY_CONTROLLER_DATA_SIZE = 32;
  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [CNT_W-1:0] offset;
  } tag_t;

endpackage

// File: rtl/memchr_reader_if.sv
// rtl/memchr_reader_if.sv - memory_controller bus between a read master and the RAM side
interface memchr_reader_if
  import memchr_reader_pkg::*;
#(
  parameter int ADDR_W = MEMORY_CONTROLLER_ADDR_SIZE,
  parameter int DATA_W = MEMORY_CONTROLLER_DATA_SIZE
);
  logic [ADDR_W-1:0] memory_controller_address;
  logic              memory_controller_write_enable;
  logic [DATA_W-1:0] memory_controller_in;
  logic [DATA_W-1:0] memory_controller_out;

  modport master (
    output memory_controller_address,
    output memory_controller_write_enable,
    output memory_controller_in,
    input  memory_controller_out
  );

  modport slave (
    input  memory_controller_address,
    input  memory_controller_write_enable,
    input  memory_controller_in,
    output memory_controller_out
  );
endinterface

// File: rtl/memchr_tag_pipe.sv
// rtl/memchr_tag_pipe.sv - DEPTH-deep {valid, offset} shift register aligned to RAM read latency
module memchr_tag_pipe
  import memchr_reader_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  tag_t push,
  output tag_t head
);

  tag_t stage [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (flush) begin
      // flush also drops the entry being pushed this cycle
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= push;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign head = stage[DEPTH-1];

endmodule

// File: rtl/memchr_reader.sv
// rtl/memchr_reader.sv - scans n bytes from m through memory_controller for the first byte equal to c
module memchr_reader
  import memchr_reader_pkg::*;
#(
  parameter int ADDR_W       = MEMORY_CONTROLLER_ADDR_SIZE,
  parameter int DATA_W       = MEMORY_CONTROLLER_DATA_SIZE,
  parameter int CMP_W        = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              finish,
  output logic [ADDR_W-1:0] return_val,
  output logic              found,
  input  logic [ADDR_W-1:0] m,
  input  logic [31:0]       c,
  input  logic [31:0]       n,
  memchr_reader_if.master   mem
);

  state_t            state;
  logic [ADDR_W-1:0] m_l;
  logic [CMP_W-1:0]  c_l;
  logic [CNT_W-1:0]  n_l;
  logic [CNT_W-1:0]  issue_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              res_found;
  logic [ADDR_W-1:0] res_val;

  tag_t              tag_push;
  tag_t              tag_head;
  logic              scanning;
  logic              hit;
  logic              last_tag;
  logic [ADDR_W-1:0] issue_addr;
  logic [ADDR_W-1:0] hit_addr;
  logic              unused_bits;

  assign scanning   = (state == ST_ISSUE) || (state == ST_DRAIN);
  assign hit        = scanning && tag_head.valid &&
                      (mem.memory_controller_out[CMP_W-1:0] == c_l);
  assign last_tag   = tag_head.valid && (tag_head.offset == n_l - 32'd1);
  assign issue_addr = m_l + ADDR_W'(issue_cnt);
  assign hit_addr   = m_l + ADDR_W'(tag_head.offset);

  assign tag_push.valid  = (state == ST_ISSUE);
  assign tag_push.offset = issue_cnt;

  memchr_tag_pipe #(.DEPTH(READ_LATENCY)) u_tag_pipe (
    .clk   (clk),
    .reset (reset),
    .flush (hit),
    .push  (tag_push),
    .head  (tag_head)
  );

  // address reaches the RAM in the issue cycle itself so data lines up with the tag head
  assign mem.memory_controller_address      = (state == ST_ISSUE) ? issue_addr : addr_q;
  assign mem.memory_controller_write_enable = 1'b0;
  assign mem.memory_controller_in           = '0;

  assign unused_bits = ^{c[31:CMP_W], mem.memory_controller_out[DATA_W-1:CMP_W]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      m_l        <= '0;
      c_l        <= '0;
      n_l        <= '0;
      issue_cnt  <= '0;
      addr_q     <= '0;
      res_found  <= 1'b0;
      res_val    <= '0;
      finish     <= 1'b0;
      found      <= 1'b0;
      return_val <= '0;
    end else begin
      finish <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            m_l       <= m;
            c_l       <= c[CMP_W-1:0];
            n_l       <= n;
            issue_cnt <= '0;
            if (n == 32'd0) begin
              res_found <= 1'b0;
              res_val   <= '0;
              state     <= ST_DONE;
            end else begin
              state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          addr_q    <= issue_addr;
          issue_cnt <= issue_cnt + 32'd1;
          if (hit) begin
            res_found <= 1'b1;
            res_val   <= hit_addr;
            state     <= ST_DONE;
          end else if (issue_cnt + 32'd1 == n_l) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (hit) begin
            res_found <= 1'b1;
            res_val   <= hit_addr;
            state     <= ST_DONE;
          end else if (last_tag) begin
            res_found <= 1'b0;
            res_val   <= '0;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          // results change only together with the finish pulse
          finish     <= 1'b1;
          found      <= res_found;
          return_val <= res_val;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
